// File: rtl/ext_bus_ctl.sv
// External-peripheral bus controller: decodes a contiguous address window into
// NUM_SLV equal regions and runs a registered request/ready handshake with the
// selected slave, with busy/done status, unmapped-address errors and a watchdog.
module ext_bus_ctl #(
  parameter int unsigned                  ADDR_WIDTH  = 32,
  parameter int unsigned                  DATA_WIDTH  = 32,
  parameter int unsigned                  NUM_SLV     = 4,
  parameter logic [ADDR_WIDTH-1:0]        BASE_ADDR   = 32'hF0000000,
  parameter int unsigned                  REGION_BITS = 8,
  parameter int unsigned                  TIMEOUT     = 16
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst,
  input  logic                            op,
  input  logic                            rw,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]           data_w,
  output logic [DATA_WIDTH-1:0]           data_r,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [NUM_SLV-1:0]              slv_sel,
  output logic                            slv_rw,
  output logic [REGION_BITS-1:0]          slv_addr,
  output logic [DATA_WIDTH-1:0]           slv_wdata,
  input  logic [NUM_SLV*DATA_WIDTH-1:0]   slv_rdata,
  input  logic [NUM_SLV-1:0]              slv_ready
);

  localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Window bounds held one bit wider than the address so the end cannot wrap.
  localparam logic [ADDR_WIDTH:0] BASE_X   = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_SIZE = (ADDR_WIDTH+1)'(NUM_SLV) << REGION_BITS;
  localparam logic [ADDR_WIDTH:0] WIN_END  = BASE_X + WIN_SIZE;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    sel_idx;
  logic [CNT_W-1:0]    cnt;

  logic [ADDR_WIDTH:0] addr_x;
  logic [ADDR_WIDTH:0] off_x;
  logic                hit;
  logic [IDX_W-1:0]    dec_idx;
  logic                sel_ready;
  logic [DATA_WIDTH-1:0] sel_rdata;

  // Address decode of the incoming request and mux of the latched slave's response.
  always_comb begin
    addr_x    = {1'b0, addr};
    off_x     = addr_x - BASE_X;
    hit       = (addr_x >= BASE_X) && (addr_x < WIN_END);
    dec_idx   = IDX_W'(off_x >> REGION_BITS);
    sel_ready = slv_ready[sel_idx];
    sel_rdata = slv_rdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  // Status flags are a direct decode of the state register.
  assign busy = (state != IDLE);
  assign done = (state == RESP);

  // Request/response FSM with registered slave-side outputs and watchdog.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_idx   <= '0;
      data_r    <= '0;
      err       <= 1'b0;
      slv_sel   <= '0;
      slv_rw    <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op) begin
            if (hit) begin
              slv_rw    <= rw;
              slv_addr  <= addr[REGION_BITS-1:0];
              slv_wdata <= data_w;
              sel_idx   <= dec_idx;
              slv_sel   <= NUM_SLV'(1) << dec_idx;
              cnt       <= '0;
              state     <= ACCESS;
            end else begin
              data_r <= '0;
              err    <= 1'b1;
              state  <= RESP;
            end
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            data_r  <= slv_rw ? '0 : sel_rdata;
            err     <= 1'b0;
            slv_sel <= '0;
            state   <= RESP;
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            data_r  <= '0;
            err     <= 1'b1;
            slv_sel <= '0;
            state   <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_ctl.sv
// Directed testbench for ext_bus_ctl: a simple slave responder with a
// programmable wait count, plus hand-computed expectations for each step.
module tb_ext_bus_ctl;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          op;
  logic          rw;
  logic [31:0]   addr;
  logic [31:0]   data_w;
  logic [31:0]   data_r;
  logic          busy;
  logic          done;
  logic          err;
  logic [3:0]    slv_sel;
  logic          slv_rw;
  logic [7:0]    slv_addr;
  logic [31:0]   slv_wdata;
  logic [127:0]  slv_rdata;
  logic [3:0]    slv_ready;

  int            wait_k;
  int            resp_cnt;
  logic [3:0]    stray;
  int            n_cmp;
  int            n_fail;
  int            lat;
  int            dones;
  int            errs;

  ext_bus_ctl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_SLV    (4),
    .BASE_ADDR  (32'hF0000000),
    .REGION_BITS(8),
    .TIMEOUT    (16)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .op       (op),
    .rw       (rw),
    .addr     (addr),
    .data_w   (data_w),
    .data_r   (data_r),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .slv_sel  (slv_sel),
    .slv_rw   (slv_rw),
    .slv_addr (slv_addr),
    .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata),
    .slv_ready(slv_ready)
  );

  always #5 sys_clk = ~sys_clk;

  // Slave model: the selected slave raises ready after wait_k selected cycles.
  always @(posedge sys_clk) begin
    if (slv_sel != 4'b0) resp_cnt <= resp_cnt + 1;
    else                 resp_cnt <= 0;
  end

  assign slv_ready = ((resp_cnt >= wait_k) ? slv_sel : 4'b0) | stray;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents op for exactly one sampling edge; returns at the following negedge.
  task automatic start_op(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge sys_clk);
    op = 1'b1; rw = w; addr = a; data_w = d;
    @(posedge sys_clk);
    @(negedge sys_clk);
    op = 1'b0;
  endtask

  // Counts edges from the op-sampling edge until done is seen; 0 if it never came.
  task automatic wait_done(output int l);
    l = 1;
    while (!done && l < 100) begin
      @(negedge sys_clk);
      l++;
    end
    if (!done) l = 0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    resp_cnt = 0; wait_k = 0; stray = 4'b0;
    slv_rdata = {32'hCAFEF00D, 32'h55AA55AA, 32'hDEADBEEF, 32'h0BADF00D};
    sys_rst = 1'b0; op = 1'b1; rw = 1'b0; addr = 32'hF0000104; data_w = 32'hFFFFFFFF;

    // 1. reset with op held high
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_outs", {data_r, busy, done, err, slv_sel, slv_rw, slv_addr},
          {32'h0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 8'h0});
    check("reset_wdata", slv_wdata, 32'h0);
    op = 1'b0; sys_rst = 1'b1;

    // 2. read slave 1, no wait
    wait_k = 0;
    start_op(1'b0, 32'hF0000104, 32'h0);
    check("rd1_sel", slv_sel, 4'b0010);
    check("rd1_addr", slv_addr, 8'h04);
    check("rd1_busy", busy, 1'b1);
    wait_done(lat);
    check("rd1_lat", lat, 2);
    check("rd1_data", data_r, 32'hDEADBEEF);
    check("rd1_err", err, 1'b0);

    // 3. write slave 3, three wait states
    wait_k = 3;
    start_op(1'b1, 32'hF0000300, 32'h12345678);
    check("wr3_sel", slv_sel, 4'b1000);
    check("wr3_wdata", slv_wdata, 32'h12345678);
    check("wr3_rw", slv_rw, 1'b1);
    wait_done(lat);
    check("wr3_lat", lat, 5);
    check("wr3_data", data_r, 32'h0);
    check("wr3_err", err, 1'b0);

    // 4. unmapped: just past the window and just below it
    wait_k = 0;
    start_op(1'b0, 32'hF0000400, 32'h0);
    check("miss_hi_sel", slv_sel, 4'b0);
    wait_done(lat);
    check("miss_hi_lat", lat, 1);
    check("miss_hi_err", {err, data_r}, {1'b1, 32'h0});
    start_op(1'b0, 32'hEFFFFFFF, 32'h0);
    check("miss_lo_sel", slv_sel, 4'b0);
    wait_done(lat);
    check("miss_lo_lat", lat, 1);
    check("miss_lo_err", {err, data_r}, {1'b1, 32'h0});

    // boundary: last byte of the window goes to slave 3 and clears err
    start_op(1'b0, 32'hF00003FF, 32'h0);
    check("last_sel", slv_sel, 4'b1000);
    check("last_addr", slv_addr, 8'hFF);
    wait_done(lat);
    check("last_lat", lat, 2);
    check("last_resp", {err, data_r}, {1'b0, 32'hCAFEF00D});

    // 5. timeout on slave 0 with a stray ready from slave 2
    wait_k = 1000;
    stray = 4'b0100;
    start_op(1'b0, 32'hF0000000, 32'h0);
    check("to_sel", slv_sel, 4'b0001);
    wait_done(lat);
    check("to_lat", lat, 17);
    check("to_sel_drop", slv_sel, 4'b0);
    check("to_resp", {err, data_r}, {1'b1, 32'h0});
    stray = 4'b0;

    // 6a. op held high continuously: one access every three cycles
    wait_k = 0;
    @(negedge sys_clk);
    op = 1'b1; rw = 1'b0; addr = 32'hF0000010;
    dones = 0; errs = 0;
    repeat (30) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (done) begin
        dones++;
        if (err || data_r !== 32'h0BADF00D) errs++;
      end
    end
    op = 1'b0;
    check("b2b_dones", dones, 10);
    check("b2b_bad", errs, 0);
    check("b2b_idle", busy, 1'b0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("b2b_no_extra", busy, 1'b0);

    // 6b. reset during ACCESS drops the transfer without a done pulse
    wait_k = 1000;
    start_op(1'b0, 32'hF0000200, 32'h0);
    @(negedge sys_clk);
    check("mid_busy", busy, 1'b1);
    sys_rst = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    check("mid_rst", {busy, done, err, slv_sel, data_r}, {1'b0, 1'b0, 1'b0, 4'b0, 32'h0});
    dones = 0;
    repeat (4) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (done || busy) dones++;
    end
    check("mid_quiet", dones, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
